// File: rtl/alu_arbiter_if.sv
// Bundle of requester handshakes, operand buses and the shared-ALU hookup
// between the two requesters and the arbiter.
interface alu_arbiter_if;
  logic        req0;
  logic [3:0]  op0;
  logic [15:0] a0;
  logic [15:0] b0;
  logic        req1;
  logic [3:0]  op1;
  logic [15:0] a1;
  logic [15:0] b1;
  logic [3:0]  alu_op;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic [15:0] alu_out;
  logic [2:0]  alu_flag;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic [15:0] result;
  logic [2:0]  flags;

  modport slave (
    input  req0, op0, a0, b0, req1, op1, a1, b1, alu_out, alu_flag,
    output gnt0, gnt1, done0, done1, result, flags, alu_op, alu_in1, alu_in2
  );

  modport master (
    output req0, op0, a0, b0, req1, op1, a1, b1, alu_out, alu_flag,
    input  gnt0, gnt1, done0, done1, result, flags, alu_op, alu_in1, alu_in2
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters;
// each granted operation runs IDLE -> EXEC -> DONE with operands latched at grant.
module alu_arbiter (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic        gnt0_reg, gnt0_next;
  logic        gnt1_reg, gnt1_next;
  logic        done0_reg, done0_next;
  logic        done1_reg, done1_next;
  logic        last1_reg, last1_next;
  logic [3:0]  op_reg, op_next;
  logic [15:0] in1_reg, in1_next;
  logic [15:0] in2_reg, in2_next;
  logic [15:0] result_reg, result_next;
  logic [2:0]  flags_reg, flags_next;
  logic        win1;
  logic        exec_active;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign win1        = bus.req1 & (~bus.req0 | ~last1_reg);
  assign exec_active = (state_reg == EXEC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      gnt0_reg   <= 1'b0;
      gnt1_reg   <= 1'b0;
      done0_reg  <= 1'b0;
      done1_reg  <= 1'b0;
      last1_reg  <= 1'b1;
      op_reg     <= 4'd0;
      in1_reg    <= 16'd0;
      in2_reg    <= 16'd0;
      result_reg <= 16'd0;
      flags_reg  <= 3'b000;
    end else begin
      state_reg  <= state_next;
      gnt0_reg   <= gnt0_next;
      gnt1_reg   <= gnt1_next;
      done0_reg  <= done0_next;
      done1_reg  <= done1_next;
      last1_reg  <= last1_next;
      op_reg     <= op_next;
      in1_reg    <= in1_next;
      in2_reg    <= in2_next;
      result_reg <= result_next;
      flags_reg  <= flags_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    gnt0_next   = gnt0_reg;
    gnt1_next   = gnt1_reg;
    done0_next  = 1'b0;
    done1_next  = 1'b0;
    last1_next  = last1_reg;
    op_next     = op_reg;
    in1_next    = in1_reg;
    in2_next    = in2_reg;
    result_next = result_reg;
    flags_next  = flags_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          gnt0_next  = ~win1;
          gnt1_next  = win1;
          last1_next = win1;
          op_next    = win1 ? bus.op1 : bus.op0;
          in1_next   = win1 ? bus.a1  : bus.a0;
          in2_next   = win1 ? bus.b1  : bus.b0;
          state_next = EXEC;
        end
      end
      EXEC: begin
        result_next = bus.alu_out;
        // Only the execute stage owns the architectural flags.
        if (gnt0_reg) begin
          case (op_reg)
            4'b0000, 4'b0001: flags_next = bus.alu_flag;
            4'b0010, 4'b0100, 4'b0101,
            4'b0110, 4'b0111: flags_next[2] = bus.alu_flag[2];
            default: ;
          endcase
        end
        state_next = DONE;
      end
      DONE: begin
        done0_next = gnt0_reg;
        done1_next = gnt1_reg;
        gnt0_next  = 1'b0;
        gnt1_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.alu_op  = exec_active ? op_reg  : 4'd0;
  assign bus.alu_in1 = exec_active ? in1_reg : 16'd0;
  assign bus.alu_in2 = exec_active ? in2_reg : 16'd0;
  assign bus.gnt0    = gnt0_reg;
  assign bus.gnt1    = gnt1_reg;
  assign bus.done0   = done0_reg;
  assign bus.done1   = done1_reg;
  assign bus.result  = result_reg;
  assign bus.flags   = flags_reg;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU closes the loop and a
// scoreboard queue holds the expected outcome of every issued request.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        who;
    logic [15:0] res;
    logic [2:0]  flg;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] exp_flags;
  int         checks   = 0;
  int         failures = 0;

  // Returns {Z, V, N, result}.
  function automatic logic [18:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [15:0] r;
    logic        v;
    v = 1'b0;
    case (op)
      4'd0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      4'd1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
      4'd2: r = a ^ b;
      4'd4: r = a << b[3:0];
      4'd5: r = a >> b[3:0];
      4'd6: r = $signed(a) >>> b[3:0];
      4'd7: r = a | b;
      4'd8: r = {a[15:8], b[7:0]};
      4'd9: r = {b[7:0], a[7:0]};
      default: r = a & b;
    endcase
    return {(r == 16'd0), v, r[15], r};
  endfunction

  always_comb {bus.alu_flag, bus.alu_out} = alu_fn(bus.alu_op, bus.alu_in1, bus.alu_in2);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic who, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b);
    logic [18:0] f;
    exp_t        e;
    f = alu_fn(op, a, b);
    if (!who) begin
      case (op)
        4'd0, 4'd1: exp_flags = f[18:16];
        4'd2, 4'd4, 4'd5, 4'd6, 4'd7: exp_flags[2] = f[18];
        default: ;
      endcase
    end
    e.who = who;
    e.res = f[15:0];
    e.flg = exp_flags;
    sb.push_back(e);
  endtask

  task automatic drive_req(input logic who, input logic req, input logic [3:0] op,
                           input logic [15:0] a, input logic [15:0] b);
    if (!who) begin
      bus.req0 = req; bus.op0 = op; bus.a0 = a; bus.b0 = b;
    end else begin
      bus.req1 = req; bus.op1 = op; bus.a1 = a; bus.b1 = b;
    end
  endtask

  task automatic wait_done(output logic who, output int n);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      n++;
      if (bus.done0 | bus.done1) break;
    end
    chk("done_seen", {31'd0, bus.done0 | bus.done1}, 32'd1);
    chk("done_onehot", {31'd0, bus.done0 & bus.done1}, 32'd0);
    chk("gnt_cleared_at_done", {30'd0, bus.gnt0, bus.gnt1}, 32'd0);
    who = bus.done1;
  endtask

  task automatic pop_check(input logic who);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL sb_empty observed=0 expected=nonzero");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("done_who", {31'd0, who}, {31'd0, e.who});
      chk("result", {16'd0, bus.result}, {16'd0, e.res});
      chk("flags", {29'd0, bus.flags}, {29'd0, e.flg});
      $display("txn who=%0d result=%h flags=%b", who, bus.result, bus.flags);
    end
  endtask

  task automatic run_single(input logic who, input logic [3:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic perturb);
    int   n;
    logic w;
    drive_req(who, 1'b1, op, a, b);
    push_exp(who, op, a, b);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n++;
      if (who ? bus.gnt1 : bus.gnt0) break;
    end
    chk("gnt_latency", n, 32'd1);
    chk("gnt_onehot", {31'd0, bus.gnt0 & bus.gnt1}, 32'd0);
    chk("alu_op_exec", {28'd0, bus.alu_op}, {28'd0, op});
    chk("alu_in1_exec", {16'd0, bus.alu_in1}, {16'd0, a});
    if (perturb) drive_req(who, 1'b0, op, 16'h0100, b);
    wait_done(w, n);
    chk("done_latency", n, 32'd2);
    chk("alu_idle_zero", {bus.alu_op, bus.alu_in1, bus.alu_in2}, 36'd0);
    pop_check(w);
    drive_req(who, 1'b0, op, a, b);
  endtask

  initial begin
    int   n;
    int   cnt;
    logic w;
    rst = 1'b1;
    drive_req(1'b0, 1'b0, 4'd0, 16'd0, 16'd0);
    drive_req(1'b1, 1'b0, 4'd0, 16'd0, 16'd0);
    exp_flags = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", {30'd0, bus.gnt0, bus.gnt1}, 32'd0);
    chk("rst_done", {30'd0, bus.done0, bus.done1}, 32'd0);
    chk("rst_result", {16'd0, bus.result}, 32'd0);
    chk("rst_flags", {29'd0, bus.flags}, 32'd0);
    chk("rst_alu", {bus.alu_op, bus.alu_in1, bus.alu_in2}, 36'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Overflowing add, then requester 1 must leave flags alone.
    run_single(1'b0, 4'b0000, 16'h7FFF, 16'h0001, 1'b0);
    run_single(1'b1, 4'b0001, 16'h0005, 16'h0005, 1'b0);
    // XOR touches Z only; LLB touches nothing.
    run_single(1'b0, 4'b0010, 16'h1234, 16'h1234, 1'b0);
    run_single(1'b0, 4'b1000, 16'hAB00, 16'h00CD, 1'b0);
    // Inputs change right after the grant; the latched operands must win.
    run_single(1'b0, 4'b0000, 16'h0003, 16'h0004, 1'b1);
    run_single(1'b0, 4'b0000, 16'h7FFF, 16'h0001, 1'b0);

    // Reset while the operation is in EXEC.
    drive_req(1'b0, 1'b1, 4'b0000, 16'h7FFF, 16'h0001);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n++;
      if (bus.gnt0) break;
    end
    chk("abort_gnt_latency", n, 32'd1);
    rst = 1'b1;
    drive_req(1'b0, 1'b0, 4'b0000, 16'h7FFF, 16'h0001);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_flags = 3'b000;
    chk("abort_gnt", {30'd0, bus.gnt0, bus.gnt1}, 32'd0);
    chk("abort_result", {16'd0, bus.result}, 32'd0);
    chk("abort_flags", {29'd0, bus.flags}, 32'd0);
    chk("abort_alu", {bus.alu_op, bus.alu_in1, bus.alu_in2}, 36'd0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.done0 | bus.done1) cnt++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", cnt, 32'd0);
    $display("txn abort rst_in_exec done_pulses=%0d", cnt);

    // Both requesters held: tie goes to 0 after reset, then strict alternation.
    drive_req(1'b0, 1'b1, 4'b0000, 16'hFFFF, 16'h0001);
    drive_req(1'b1, 1'b1, 4'b0001, 16'h0009, 16'h0004);
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) push_exp(1'b0, 4'b0000, 16'hFFFF, 16'h0001);
      else            push_exp(1'b1, 4'b0001, 16'h0009, 16'h0004);
    end
    for (int k = 0; k < 6; k++) begin
      wait_done(w, n);
      chk("alt_spacing", n, 32'd3);
      pop_check(w);
    end
    drive_req(1'b0, 1'b0, 4'b0000, 16'hFFFF, 16'h0001);
    drive_req(1'b1, 1'b0, 4'b0001, 16'h0009, 16'h0004);
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 req0  input  1  requester 0 (execute stage) request; held until done0.
REQ-004 op0  input  4  requester 0 ALUOp code.
REQ-005 a0, b0  input  16 each  requester 0 operands In1/In2.
REQ-006 req1  input  1  requester 1 (address unit) request; held until done1.
REQ-007 op1  input  4  requester 1 ALUOp code.
REQ-008 a1, b1  input  16 each  requester 1 operands.
REQ-009 alu_op  output  4  ALUOp driven to the shared ALU.
REQ-010 alu_in1, alu_in2  output  16 each  operands driven to the shared ALU.
REQ-011 alu_out  input  16  combinational ALU result.
REQ-012 alu_flag  input  3  combinational ALU flags {Z,V,N}.
REQ-013 gnt0, gnt1  output  1 each  one-hot grant, registered.
REQ-014 done0, done1  output  1 each  single-cycle completion pulse.
REQ-015 result  output  16  registered result, valid while done0 or done1 is high.
REQ-016 flags  output  3  architectural flag register {Z,V,N}.

Function
REQ-017 FSM states IDLE, EXEC, DONE; encoding is implementation choice.
REQ-018 IDLE: if any req high, pick winner, latch its op/operands into internal registers, set its gnt, go EXEC; else stay IDLE.
REQ-019 Arbitration round-robin: single req wins; both high -> requester not granted last; last-granted pointer updated on every grant.
REQ-020 EXEC (exactly one cycle): drive alu_op/alu_in1/alu_in2 from latched registers; capture alu_out into result; go DONE.
REQ-021 DONE (exactly one cycle): pulse done of granted requester, clear gnt, go IDLE; reqs not evaluated in DONE.
REQ-022 Latency: req sampled high in IDLE at edge N -> gnt high after N, done high after N+2; min spacing between grants 3 cycles.
REQ-023 alu_op/alu_in1/alu_in2 SHALL be 0 in IDLE and DONE.
REQ-024 req or operand changes after grant SHALL not affect the in-flight operation; done still pulses.
REQ-025 Flag update only at EXEC->DONE edge and only when granted requester is 0; requester 1 never writes flags.
REQ-026 op 0000/0001 (ADD/SUB): flags <= alu_flag (Z,V,N all).
REQ-027 op 0010,0100,0101,0110,0111: update Z only; V,N hold.
REQ-028 op 1000,1001,1010 and all other codes: flags hold.
REQ-029 result holds its last value outside DONE; gnt0&gnt1 and done0&done1 never both high.

Reset
REQ-030 rst high at edge: state IDLE, gnt0=gnt1=0, done0=done1=0, result=0, flags=3'b000, ALU drives 0, pointer set so requester 0 wins first tie.
REQ-031 rst during EXEC or DONE aborts: no done pulse, no flag update; rst priority over all events.

Verification
REQ-032 req0 ADD a0=16'h7FFF b0=16'h0001 -> done0 at +2 cycles, result=16'h8000, flags={0,1,1}.
REQ-033 req0 and req1 asserted same cycle after reset -> requester 0 granted first, requester 1 next grant; held both -> alternating 0,1,0,1.
REQ-034 req1 SUB a1=b1=16'h0005 -> result=16'h0000, done1 pulses, flags unchanged from prior value.
REQ-035 flags={0,1,1}, req0 XOR a0=b0=16'h1234 -> result=0, flags={1,1,1}; then LLB op 1000 -> flags unchanged.
REQ-036 rst asserted in EXEC of req0 ADD -> next cycle IDLE, no done0, flags=000, result=0.
REQ-037 req0 dropped and a0 changed the cycle after grant -> done0 still pulses with result from originally latched operands.
